// File: rtl/powerrom_arbiter_if.sv
// Bundle of requester-side handshake, ROM port and response signals shared by the
// round-robin power-ROM arbiter and its clients.
interface powerrom_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int IW   = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    grant;
    logic [AW-1:0]      rom_address;
    logic [DW-1:0]      rom_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               busy;

    modport master (
        output req, req_addr, rom_data,
        input  grant, rom_address, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req, req_addr, rom_data,
        output grant, rom_address, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/powerrom_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle ROM among NREQ requesters;
// fixed two-edge accept-to-response pipeline, one lookup per clock.
module powerrom_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int IW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    powerrom_arbiter_if.slave  bus
);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [IW-1:0]   s1_id_q, s1_id_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;

    logic            any_s;
    logic [IW-1:0]   winner_s;
    logic [NREQ-1:0] grant_s;
    int              scan_s;

    // Rotating priority scan starting at ptr; first requester found wins.
    always_comb begin
        any_s    = 1'b0;
        winner_s = '0;
        scan_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_s = int'(ptr_q) + k;
            if (scan_s >= NREQ) begin
                scan_s = scan_s - NREQ;
            end else begin
                scan_s = scan_s;
            end
            if (!any_s && bus.req[scan_s]) begin
                any_s    = 1'b1;
                winner_s = IW'(scan_s);
            end else begin
                any_s    = any_s;
            end
        end
        if (any_s) begin
            grant_s = ONE_HOT0 << winner_s;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state for the address stage, pointer and response stage.
    always_comb begin
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        s1_valid_d = 1'b0;
        s1_id_d    = s1_id_q;
        if (any_s) begin
            addr_d     = bus.req_addr[winner_s*AW +: AW];
            s1_valid_d = 1'b1;
            s1_id_d    = winner_s;
            if (winner_s == IW'(NREQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner_s + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
        if (s1_valid_q) begin
            rsp_valid_d = ONE_HOT0 << s1_id_q;
        end else begin
            rsp_valid_d = '0;
        end
        rsp_id_d = s1_id_q;
    end

    // Pipeline registers; reset drops any in-flight lookup without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.grant       = grant_s;
    assign bus.rom_address = addr_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = bus.rom_data;
    assign bus.busy        = s1_valid_q | (|rsp_valid_q);
endmodule

// File: tb/tb_powerrom_arbiter.sv
// Directed self-checking bench for powerrom_arbiter with a behavioural 1-cycle ROM.
module tb_powerrom_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int IW   = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    powerrom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IW(IW)) bus ();

    powerrom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        case (a)
            8'd0:    rom_fn = 16'd0;
            8'd1:    rom_fn = 16'd3;
            8'd44:   rom_fn = 16'd130;
            8'd128:  rom_fn = 16'd424;
            8'd250:  rom_fn = 16'd991;
            8'd251:  rom_fn = 16'd996;
            8'd252:  rom_fn = 16'd1002;
            8'd253:  rom_fn = 16'd1007;
            8'd254:  rom_fn = 16'd1013;
            8'd255:  rom_fn = 16'd1018;
            default: rom_fn = {8'hA5, a};
        endcase
    endfunction

    // Registered-read ROM model.
    always_ff @(posedge clk) bus.rom_data <= rom_fn(bus.rom_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.req_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL idle_grant c=%0d got %b want 0000", c, bus.grant); end
            n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL idle_rsp_valid c=%0d got %b want 0000", c, bus.rsp_valid); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy c=%0d got %b want 0", c, bus.busy); end
            n_cmp++; if (bus.rom_address !== 8'd0) begin n_fail++; $display("FAIL idle_rom_address c=%0d got %0d want 0", c, bus.rom_address); end
        end
        // two accepts, then reset lands asynchronously mid-cycle
        bus.req = 4'b0011;
        bus.req_addr = {8'd9, 8'd8, 8'd7, 8'd6};
        tick();
        tick();
        bus.req = 4'b0000;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rsp_valid got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.rom_address !== 8'd0) begin n_fail++; $display("FAIL midrst_rom_address got %0d want 0", bus.rom_address); end
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL postrst_rsp_valid c=%0d got %b want 0000", c, bus.rsp_valid); end
        end
        // pointer was 2 before reset; must restart at 0
        bus.req = 4'b1111;
        #1;
        n_cmp++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL postrst_ptr_grant got %b want 0001", bus.grant); end
        bus.req = 4'b0000;
        #1;
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        bus.req_addr = {8'd0, 8'd44, 8'd0, 8'd0};
        #1;
        n_cmp++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", bus.grant); end
        tick();
        bus.req = 4'b0000;
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.rom_address !== 8'd44) begin n_fail++; $display("FAIL single_rom_address got %0d want 44", bus.rom_address); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid got %b want 0100", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id got %0d want 2", bus.rsp_id); end
        n_cmp++; if (bus.rsp_data !== 16'd130) begin n_fail++; $display("FAIL single_rsp_data got %0d want 130", bus.rsp_data); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bus.busy); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_one_cycle got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_all_rotate();
        logic [DW-1:0]   exp_data [4];
        logic [NREQ-1:0] onehot;
        exp_data[0] = 16'd0;
        exp_data[1] = 16'd3;
        exp_data[2] = 16'd424;
        exp_data[3] = 16'd1018;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_addr = {8'd255, 8'd128, 8'd1, 8'd0};
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                bus.req = 4'b1111;
                #1;
                onehot = 4'b0001 << (c % 4);
                n_cmp++; if (bus.grant !== onehot) begin n_fail++; $display("FAIL rotate_grant c=%0d got %b want %b", c, bus.grant, onehot); end
            end else begin
                bus.req = 4'b0000;
            end
            tick();
            if (c >= 1) begin
                onehot = 4'b0001 << ((c - 1) % 4);
                n_cmp++; if (bus.rsp_valid !== onehot) begin n_fail++; $display("FAIL rotate_rsp_valid c=%0d got %b want %b", c, bus.rsp_valid, onehot); end
                n_cmp++; if (bus.rsp_id !== IW'((c - 1) % 4)) begin n_fail++; $display("FAIL rotate_rsp_id c=%0d got %0d want %0d", c, bus.rsp_id, (c - 1) % 4); end
                n_cmp++; if (bus.rsp_data !== exp_data[(c - 1) % 4]) begin n_fail++; $display("FAIL rotate_rsp_data c=%0d got %0d want %0d", c, bus.rsp_data, exp_data[(c - 1) % 4]); end
            end
        end
        tick();
    endtask

    task automatic test_ptr_wrap();
        bus.req_addr = {8'd253, 8'd0, 8'd251, 8'd0};
        bus.req = 4'b1000;
        #1;
        n_cmp++; if (bus.grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3 got %b want 1000", bus.grant); end
        tick();
        bus.req = 4'b1010;
        #1;
        n_cmp++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL wrap_first got %b want 0010", bus.grant); end
        tick();
        bus.req = 4'b1000;
        #1;
        n_cmp++; if (bus.grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_second got %b want 1000", bus.grant); end
        tick();
        bus.req = 4'b0000;
        n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL wrap_rsp1_valid got %b want 0010", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 16'd996) begin n_fail++; $display("FAIL wrap_rsp1_data got %0d want 996", bus.rsp_data); end
        tick();
        n_cmp++; if (bus.rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_rsp3_id got %0d want 3", bus.rsp_id); end
        n_cmp++; if (bus.rsp_data !== 16'd1007) begin n_fail++; $display("FAIL wrap_rsp3_data got %0d want 1007", bus.rsp_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_data [6];
        exp_data[0] = 16'd991;
        exp_data[1] = 16'd996;
        exp_data[2] = 16'd1002;
        exp_data[3] = 16'd1007;
        exp_data[4] = 16'd1013;
        exp_data[5] = 16'd1018;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) begin
                bus.req = 4'b0001;
                bus.req_addr = {8'd0, 8'd0, 8'd0, 8'(250 + c)};
                #1;
                n_cmp++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL stream_grant c=%0d got %b want 0001", c, bus.grant); end
            end else begin
                bus.req = 4'b0000;
            end
            tick();
            if (c >= 1) begin
                n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL stream_rsp_valid c=%0d got %b want 0001", c, bus.rsp_valid); end
                n_cmp++; if (bus.rsp_data !== exp_data[c - 1]) begin n_fail++; $display("FAIL stream_rsp_data c=%0d got %0d want %0d", c, bus.rsp_data, exp_data[c - 1]); end
            end
        end
        tick();
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL stream_drain got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy got %b want 0", bus.busy); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.req = '0;
        bus.req_addr = '0;
        test_reset();
        test_single();
        test_all_rotate();
        test_ptr_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
